// File: rtl/cpmath_control_if.sv
// cpmath_control_if: control-unit to datapath signal bundle
interface cpmath_control_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pcWrite;
  logic        iorD;
  logic        memRead;
  logic        memWrite;
  logic        irWrite;
  logic        regWrite;
  logic        regSrc;
  logic        dataSrc;
  logic        aSrc;
  logic [1:0]  bSrc;
  logic [1:0]  pcSrc;
  logic [5:0]  aluOp;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_count;
  modport master (
    input  opcode, funct, zero,
    output pcWrite, iorD, memRead, memWrite, irWrite, regWrite, regSrc, dataSrc,
           aSrc, bSrc, pcSrc, aluOp, state, illegal, instr_count
  );
  modport slave (
    output opcode, funct, zero,
    input  pcWrite, iorD, memRead, memWrite, irWrite, regWrite, regSrc, dataSrc,
           aSrc, bSrc, pcSrc, aluOp, state, illegal, instr_count
  );
endinterface

// File: rtl/cpmath_control.sv
// cpmath_control: multicycle Moore control FSM for the CPMath datapath
module cpmath_control (
  input logic clk,
  input logic rst,
  cpmath_control_if.master bus
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] ALU_ADD = 6'h20, ALU_SUB = 6'h22;
  logic [3:0]  state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] count_q, count_d;
  logic        funct_ok, retire, en;
  logic        s_fetch, s_decode, s_memadr, s_memrd, s_memwb, s_memwr;
  logic        s_exec, s_rwb, s_branch, s_addiex, s_addiwb, s_jump;
  assign s_fetch  = state_q == S_FETCH;
  assign s_decode = state_q == S_DECODE;
  assign s_memadr = state_q == S_MEMADR;
  assign s_memrd  = state_q == S_MEMRD;
  assign s_memwb  = state_q == S_MEMWB;
  assign s_memwr  = state_q == S_MEMWR;
  assign s_exec   = state_q == S_EXEC;
  assign s_rwb    = state_q == S_RWB;
  assign s_branch = state_q == S_BRANCH;
  assign s_addiex = state_q == S_ADDIEX;
  assign s_addiwb = state_q == S_ADDIWB;
  assign s_jump   = state_q == S_JUMP;
  assign funct_ok = bus.funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  assign retire   = s_memwb | s_memwr | s_rwb | s_branch | s_addiwb | s_jump;
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                  (bus.opcode == OP_R && funct_ok)             ? S_EXEC   :
                  (bus.opcode == OP_BEQ)                       ? S_BRANCH :
                  (bus.opcode == OP_ADDI)                      ? S_ADDIEX :
                  (bus.opcode == OP_J)                         ? S_JUMP   : S_FETCH;
        illegal_d = illegal_q | (state_d == S_FETCH);
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end
  assign count_d = count_q + {31'd0, retire};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end
  // Enables are squashed during reset so an aborted instruction has no side effects
  assign en              = ~rst;
  assign bus.pcWrite     = en & (s_fetch | s_jump | (s_branch & bus.zero));
  assign bus.memRead     = en & (s_fetch | s_memrd);
  assign bus.memWrite    = en & s_memwr;
  assign bus.irWrite     = en & s_fetch;
  assign bus.regWrite    = en & (s_memwb | s_rwb | s_addiwb);
  assign bus.iorD        = s_memrd | s_memwr;
  assign bus.regSrc      = s_rwb;
  assign bus.dataSrc     = s_rwb | s_addiwb;
  assign bus.aSrc        = s_memadr | s_addiex | s_exec | s_branch;
  assign bus.bSrc        = s_fetch ? 2'd1 : s_decode ? 2'd3 : (s_memadr | s_addiex) ? 2'd2 : 2'd0;
  assign bus.pcSrc       = s_branch ? 2'd1 : s_jump ? 2'd2 : 2'd0;
  assign bus.aluOp       = s_exec ? bus.funct : s_branch ? ALU_SUB : ALU_ADD;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;
endmodule
